// File: rtl/phase_timer_pkg.sv
// Shared definitions for the phase timer: legal lane patterns, lamp colour
// codes, the phase encoding and small helpers used when sampling a lane/time.
package phase_timer_pkg;

   localparam logic [7:0] LANE_NS = 8'b00110011;
   localparam logic [7:0] LANE_EW = 8'b11001100;

   localparam logic [1:0] COL_RED    = 2'b00;
   localparam logic [1:0] COL_YELLOW = 2'b01;
   localparam logic [1:0] COL_GREEN  = 2'b11;

   typedef enum logic [1:0] {
      PH_ALL_RED = 2'd0,
      PH_GREEN   = 2'd1,
      PH_YELLOW  = 2'd2
   } phase_e;

   // Only the two non-conflicting patterns may ever be driven green.
   function automatic logic is_legal(input logic [7:0] lane);
      return (lane == LANE_NS) || (lane == LANE_EW);
   endfunction

   // A zero duration would never expire cleanly, so it is promoted to one tick.
   function automatic logic [6:0] clamp_time(input logic [6:0] t);
      return (t == 7'd0) ? 7'd1 : t;
   endfunction

   // Turns every green direction code into yellow; red directions stay red.
   function automatic logic [7:0] yellow_of(input logic [7:0] lane);
      logic [7:0] res;
      res = '0;
      for (int i = 0; i < 4; i++) begin
         if (lane[2*i +: 2] == COL_GREEN) begin
            res[2*i +: 2] = COL_YELLOW;
         end else begin
            res[2*i +: 2] = COL_RED;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/phase_timer_tick_prescaler.sv
// Divides the system clock into timing ticks. The count restarts on request so
// every phase starts on a whole-tick boundary. tick_next tells the FSM that the
// coming edge will carry a tick, which lets it raise load_req one cycle early.
module tick_prescaler #(
   parameter int unsigned TICK_DIV = 50
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick,
   output logic tick_next
);

   localparam int unsigned W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: wrap after the last value, or start over when asked.
   always_comb begin
      count_d = count_q;
      if (restart || (count_q == LAST)) begin
         count_d = '0;
      end else begin
         count_d = count_q + 1'b1;
      end
   end

   assign tick      = (count_q == LAST);
   assign tick_next = (count_d == LAST);

   // Prescaler count register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/phase_timer.sv
// Traffic phase timer: holds the sampled lane green for its loaded duration,
// then inserts yellow and all-red clearance before any change of lane.
// load_req is raised in the cycle whose closing edge samples lane_in/load_time.
module phase_timer
   import phase_timer_pkg::*;
#(
   parameter int unsigned TICK_DIV     = 50,
   parameter int unsigned YELLOW_TIME  = 3,
   parameter int unsigned ALL_RED_TIME = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] lane_in,
   input  logic [6:0] load_time,
   output logic [7:0] lights,
   output logic       load_req,
   output logic [6:0] remaining,
   output logic [1:0] phase
);

   localparam logic [6:0] YELLOW_T  = 7'(YELLOW_TIME);
   localparam logic [6:0] ALL_RED_T = 7'(ALL_RED_TIME);

   phase_e     state_q, state_d;
   logic [7:0] active_q, active_d;
   logic [7:0] pend_lane_q, pend_lane_d;
   logic [6:0] pend_time_q, pend_time_d;
   logic       pend_valid_q, pend_valid_d;
   logic [6:0] cnt_q, cnt_d;
   logic [7:0] lights_q, lights_d;
   logic       load_req_q, load_req_d;
   logic       tick, tick_next, restart, expire;

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk       (clk),
      .rst       (rst),
      .restart   (restart),
      .tick      (tick),
      .tick_next (tick_next)
   );

   // Phase sequencing: count ticks, and on expiry decide the next phase from
   // the pending lane or from the lane/time sampled on this edge.
   always_comb begin
      state_d      = state_q;
      active_d     = active_q;
      pend_lane_d  = pend_lane_q;
      pend_time_d  = pend_time_q;
      pend_valid_d = pend_valid_q;
      cnt_d        = cnt_q;
      restart      = 1'b0;
      expire       = tick && (cnt_q == 7'd1);
      if (tick && !expire) begin
         cnt_d = cnt_q - 7'd1;
      end
      if (expire) begin
         restart = 1'b1;
         case (state_q)
            PH_ALL_RED: begin
               if (pend_valid_q) begin
                  state_d      = PH_GREEN;
                  active_d     = pend_lane_q;
                  cnt_d        = pend_time_q;
                  pend_valid_d = 1'b0;
               end else if (is_legal(lane_in)) begin
                  state_d  = PH_GREEN;
                  active_d = lane_in;
                  cnt_d    = clamp_time(load_time);
               end else begin
                  cnt_d = ALL_RED_T;
               end
            end
            PH_GREEN: begin
               if (lane_in == active_q) begin
                  cnt_d = clamp_time(load_time);
               end else if (is_legal(lane_in)) begin
                  pend_lane_d  = lane_in;
                  pend_time_d  = clamp_time(load_time);
                  pend_valid_d = 1'b1;
                  state_d      = PH_YELLOW;
                  cnt_d        = YELLOW_T;
               end else begin
                  pend_valid_d = 1'b0;
                  state_d      = PH_YELLOW;
                  cnt_d        = YELLOW_T;
               end
            end
            PH_YELLOW: begin
               state_d = PH_ALL_RED;
               cnt_d   = ALL_RED_T;
            end
            default: begin
               state_d = PH_ALL_RED;
               cnt_d   = ALL_RED_T;
            end
         endcase
      end
   end

   // Lamp drive and sample request, computed from next state so they register
   // in step with the phase; the request looks one edge ahead to the sample.
   always_comb begin
      lights_d = '0;
      case (state_d)
         PH_GREEN:  lights_d = active_d;
         PH_YELLOW: lights_d = yellow_of(active_d);
         default:   lights_d = '0;
      endcase
      load_req_d = tick_next && (cnt_d == 7'd1) &&
                   ((state_d == PH_GREEN) ||
                    ((state_d == PH_ALL_RED) && !pend_valid_d));
   end

   // All FSM state and registered outputs; reset forces lamps dark at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= PH_ALL_RED;
         active_q     <= '0;
         pend_lane_q  <= '0;
         pend_time_q  <= 7'd1;
         pend_valid_q <= 1'b0;
         cnt_q        <= ALL_RED_T;
         lights_q     <= '0;
         load_req_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         active_q     <= active_d;
         pend_lane_q  <= pend_lane_d;
         pend_time_q  <= pend_time_d;
         pend_valid_q <= pend_valid_d;
         cnt_q        <= cnt_d;
         lights_q     <= lights_d;
         load_req_q   <= load_req_d;
      end
   end

   assign lights    = lights_q;
   assign load_req  = load_req_q;
   assign remaining = cnt_q;
   assign phase     = state_q;

endmodule
